// File: rtl/junction_phase_scheduler.sv
// Three-way junction signal sequencer: main rest-on-green, demand-served turn
// and side phases, emergency preempt toward main-green.
module junction_phase_scheduler #(
  parameter int unsigned T_MAIN_MIN = 8,
  parameter int unsigned T_TURN     = 5,
  parameter int unsigned T_SIDE     = 6,
  parameter int unsigned T_YEL      = 3,
  parameter int unsigned T_AR       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_mt,
  input  logic       req_s,
  input  logic       emg,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [2:0] phase,
  output logic       emg_ack
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] MAIN_LAST = CW'(T_MAIN_MIN - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(T_TURN - 1);
  localparam logic [CW-1:0] SIDE_LAST = CW'(T_SIDE - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_AR - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    S_AR    = 3'd0,
    S_MAIN  = 3'd1,
    S_M2Y   = 3'd2,
    S_TURN  = 3'd3,
    S_CLR_Y = 3'd4,
    S_SIDE  = 3'd5
  } state_t;

  state_t          state, state_nxt;
  state_t          last_green, last_green_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pend_mt, pend_mt_nxt;
  logic            pend_s, pend_s_nxt;
  logic [2:0]      m1_nxt, m2_nxt, mt_nxt, s_nxt;
  logic            emg_ack_nxt;
  logic            entering;
  logic            want_mt, want_s;

  assign phase = state;

  // State, dwell counter, demand latches and registered light outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_AR;
      last_green <= S_MAIN;
      cnt        <= '0;
      pend_mt    <= 1'b0;
      pend_s     <= 1'b0;
      light_M1   <= RED;
      light_M2   <= RED;
      light_MT   <= RED;
      light_S    <= RED;
      emg_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_green <= last_green_nxt;
      cnt        <= cnt_nxt;
      pend_mt    <= pend_mt_nxt;
      pend_s     <= pend_s_nxt;
      light_M1   <= m1_nxt;
      light_M2   <= m2_nxt;
      light_MT   <= mt_nxt;
      light_S    <= s_nxt;
      emg_ack    <= emg_ack_nxt;
    end
  end

  // Next-state, counter/latch updates and light decode of the next state
  always_comb begin
    state_nxt      = state;
    last_green_nxt = last_green;
    cnt_nxt        = cnt;
    pend_mt_nxt    = pend_mt | req_mt;
    pend_s_nxt     = pend_s | req_s;
    m1_nxt         = RED;
    m2_nxt         = RED;
    mt_nxt         = RED;
    s_nxt          = RED;
    emg_ack_nxt    = 1'b0;
    // a request arriving in the exit-eligible MAIN cycle is honoured on that edge
    want_mt        = pend_mt | req_mt;
    want_s         = pend_s | req_s;

    case (state)
      S_AR: begin
        if (cnt == AR_LAST) begin
          if (emg)                                 state_nxt = S_MAIN;
          else if (pend_s && last_green != S_SIDE) state_nxt = S_SIDE;
          else                                     state_nxt = S_MAIN;
        end
      end
      S_MAIN: begin
        if (cnt == MAIN_LAST && !emg) begin
          if (want_mt)     state_nxt = S_M2Y;
          else if (want_s) state_nxt = S_CLR_Y;
        end
      end
      S_M2Y:   if (cnt == YEL_LAST) state_nxt = S_TURN;
      S_TURN:  if (emg || cnt == TURN_LAST) state_nxt = S_CLR_Y;
      S_SIDE:  if (emg || cnt == SIDE_LAST) state_nxt = S_CLR_Y;
      S_CLR_Y: if (cnt == YEL_LAST) state_nxt = S_AR;
      default: state_nxt = S_AR;
    endcase

    entering = (state_nxt != state);

    if (entering)                                    cnt_nxt = '0;
    else if (state == S_MAIN && cnt == MAIN_LAST)    cnt_nxt = cnt;
    else                                             cnt_nxt = cnt + CW'(1);

    if (entering && state_nxt == S_TURN) pend_mt_nxt = 1'b0;
    if (entering && state_nxt == S_SIDE) pend_s_nxt  = 1'b0;

    if (entering && (state_nxt == S_MAIN || state_nxt == S_TURN || state_nxt == S_SIDE))
      last_green_nxt = state_nxt;

    case (state_nxt)
      S_MAIN: begin m1_nxt = GRN; m2_nxt = GRN; end
      S_M2Y:  begin m1_nxt = GRN; m2_nxt = YEL; end
      S_TURN: begin m1_nxt = GRN; mt_nxt = GRN; end
      S_SIDE: s_nxt = GRN;
      S_CLR_Y: begin
        case (last_green)
          S_TURN:  begin m1_nxt = YEL; mt_nxt = YEL; end
          S_SIDE:  s_nxt = YEL;
          default: begin m1_nxt = YEL; m2_nxt = YEL; end
        endcase
      end
      default: ;
    endcase

    emg_ack_nxt = (state_nxt == S_MAIN) && emg;
  end

endmodule
